// File: rtl/apb4_master_arb.sv
// Two-requester APB4 master: round-robin arbitration between two command ports,
// SETUP/ACCESS sequencing with an ACCESS-phase timeout, and per-requester responses.
module apb4_master_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BIT    = 8,
  parameter int TIMEOUT    = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              REQ_VALID,
  output logic [1:0]              REQ_READY,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [2*STRB_WIDTH-1:0] REQ_STRB,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSEL1,
  output logic                    PSEL2,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STRB_WIDTH-1:0]   PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR,
  output logic [1:0]              state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  last_grant;
  logic                  cur_req;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  grant_any;
  logic                  grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic                  sel_write;
  logic                  timeout_hit;
  logic                  xfer_done;

  // Round-robin: on contention the requester that was not granted last wins.
  always_comb begin
    grant_any = |REQ_VALID;
    grant_idx = (&REQ_VALID) ? ~last_grant : REQ_VALID[1];
    sel_addr  = grant_idx ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]  : REQ_ADDR[ADDR_WIDTH-1:0];
    sel_wdata = grant_idx ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
    sel_strb  = grant_idx ? REQ_STRB[2*STRB_WIDTH-1:STRB_WIDTH]  : REQ_STRB[STRB_WIDTH-1:0];
    sel_write = grant_idx ? REQ_WRITE[1] : REQ_WRITE[0];
  end

  // Abort on the cycle the counter would reach TIMEOUT; PREADY in that cycle wins.
  assign timeout_hit = !PREADY && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign xfer_done   = (state == ST_ACCESS) && (PREADY || timeout_hit);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_any) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (xfer_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Command handshake: a command transfers in the cycle REQ_VALID[i] and
  // REQ_READY[i] are both high; READY is only ever raised in IDLE, for the winner.
  always_comb begin
    REQ_READY = 2'b00;
    if (PRESETn && state == ST_IDLE && grant_any) REQ_READY[grant_idx] = 1'b1;
    state_dbg = state;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      PSEL1      <= 1'b0;
      PSEL2      <= 1'b0;
      PENABLE    <= 1'b0;
      RSP_VALID  <= 2'b00;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
      last_grant <= 1'b1;
      cur_req    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      RSP_VALID <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            PADDR      <= sel_addr;
            PWRITE     <= sel_write;
            PWDATA     <= sel_wdata;
            PSTRB      <= sel_write ? sel_strb : '0;
            PSEL1      <= ~sel_addr[SEL_BIT];
            PSEL2      <= sel_addr[SEL_BIT];
            cur_req    <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          tmo_cnt <= '0;
        end
        ST_ACCESS: begin
          if (xfer_done) begin
            PSEL1              <= 1'b0;
            PSEL2              <= 1'b0;
            PENABLE            <= 1'b0;
            RSP_VALID[cur_req] <= 1'b1;
            if (PREADY) begin
              RSP_RDATA <= PWRITE ? '0 : PRDATA;
              RSP_ERR   <= PSLVERR;
            end else begin
              RSP_RDATA <= '0;
              RSP_ERR   <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_arb.sv
// Directed bench for apb4_master_arb: arbitration, APB phase timing, wait states,
// timeout abort, slave error and asynchronous reset mid-transfer.
module tb_apb4_master_arb;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          PCLK;
  logic          PRESETn;
  logic [1:0]    REQ_VALID;
  logic [1:0]    REQ_READY;
  logic [2*AW-1:0] REQ_ADDR;
  logic [1:0]    REQ_WRITE;
  logic [2*DW-1:0] REQ_WDATA;
  logic [2*SW-1:0] REQ_STRB;
  logic [1:0]    RSP_VALID;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;
  logic [AW-1:0] PADDR;
  logic          PSEL1;
  logic          PSEL2;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  logic [1:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int acc;

  apb4_master_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_BIT(8), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PADDR(PADDR), .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    PRESETn = 1'b0; REQ_VALID = 2'b00; REQ_ADDR = '0; REQ_WRITE = 2'b00;
    REQ_WDATA = '0; REQ_STRB = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    tick(); tick();
    check("rst_ctrl", {REQ_READY, RSP_VALID, RSP_ERR, PSEL1, PSEL2, PENABLE, PWRITE}, 64'h0);
    check("rst_data", {PADDR, PWDATA}, 64'h0);
    check("rst_misc", {RSP_RDATA, PSTRB, state_dbg}, 64'h0);
    PRESETn = 1'b1;
    tick();

    // Requester 0 write to slave 1, zero-wait slave (PREADY high from the start)
    REQ_ADDR[AW-1:0] = 32'h0000_0004; REQ_WDATA[DW-1:0] = 32'hDEAD_BEEF;
    REQ_STRB[SW-1:0] = 4'hF; REQ_WRITE[0] = 1'b1; REQ_VALID = 2'b01;
    PREADY = 1'b1; PRDATA = 32'h5555_AAAA;
    #1;
    check("t1_ready", REQ_READY, 2'b01);
    tick(); REQ_VALID = 2'b00;
    check("t1_setup_sel", {PSEL1, PSEL2, PENABLE}, 3'b100);
    check("t1_setup_state", state_dbg, 2'd1);
    check("t1_paddr", PADDR, 32'h4);
    check("t1_pwrite", PWRITE, 1'b1);
    check("t1_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("t1_pstrb", PSTRB, 4'hF);
    check("t1_ready_setup", REQ_READY, 2'b00);
    tick();
    check("t1_access_sel", {PSEL1, PSEL2, PENABLE}, 3'b101);
    check("t1_access_state", state_dbg, 2'd2);
    check("t1_access_paddr", PADDR, 32'h4);
    tick();
    check("t1_rsp_valid", RSP_VALID, 2'b01);
    check("t1_rsp_err", RSP_ERR, 1'b0);
    check("t1_rsp_rdata", RSP_RDATA, 32'h0);
    check("t1_bus_idle", {PSEL1, PSEL2, PENABLE}, 3'b000);
    tick();
    check("t1_rsp_pulse", RSP_VALID, 2'b00);
    PREADY = 1'b0;

    // Requester 1 read to slave 2 with one wait state; strobes forced to 0
    REQ_ADDR[2*AW-1:AW] = 32'h0000_0104; REQ_WRITE[1] = 1'b0;
    REQ_STRB[2*SW-1:SW] = 4'hF; REQ_WDATA[2*DW-1:DW] = 32'h0BAD_0BAD; REQ_VALID = 2'b10;
    #1;
    check("t2_ready", REQ_READY, 2'b10);
    tick(); REQ_VALID = 2'b00;
    check("t2_setup_sel", {PSEL1, PSEL2, PENABLE}, 3'b010);
    check("t2_pstrb", PSTRB, 4'h0);
    check("t2_pwrite", PWRITE, 1'b0);
    check("t2_paddr", PADDR, 32'h104);
    tick();
    check("t2_access", {PSEL1, PSEL2, PENABLE}, 3'b011);
    tick();
    check("t2_wait", {PSEL1, PSEL2, PENABLE}, 3'b011);
    PREADY = 1'b1; PRDATA = 32'h1234_5678;
    tick();
    check("t2_rsp_valid", RSP_VALID, 2'b10);
    check("t2_rsp_rdata", RSP_RDATA, 32'h1234_5678);
    check("t2_rsp_err", RSP_ERR, 1'b0);
    PREADY = 1'b0;

    // Both requesters valid for four zero-wait transfers: grants alternate 0,1,0,1
    REQ_ADDR[AW-1:0] = 32'h10; REQ_WRITE[0] = 1'b1; REQ_WDATA[DW-1:0] = 32'h1111_0000;
    REQ_ADDR[2*AW-1:AW] = 32'h120; REQ_WRITE[1] = 1'b0;
    PRDATA = 32'hA5A5_0001; PREADY = 1'b1; REQ_VALID = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t3_ready", REQ_READY, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("t3_paddr", PADDR, (k % 2 == 0) ? 32'h10 : 32'h120);
      check("t3_psel", {PSEL1, PSEL2}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick(); tick();
      check("t3_rsp_valid", RSP_VALID, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("t3_rsp_rdata", RSP_RDATA, (k % 2 == 0) ? 32'h0 : 32'hA5A5_0001);
    end
    REQ_VALID = 2'b00; PREADY = 1'b0;
    tick();
    check("t3_no_xfer", {PSEL1, PSEL2, PENABLE, RSP_VALID}, 5'b0);

    // PREADY stuck low: abort after exactly 16 ACCESS cycles
    REQ_ADDR[AW-1:0] = 32'h8; REQ_WRITE[0] = 1'b0; PRDATA = 32'hFFFF_FFFF; REQ_VALID = 2'b01;
    #1;
    check("t4_ready", REQ_READY, 2'b01);
    tick(); REQ_VALID = 2'b00;
    tick();
    acc = 0;
    for (int i = 0; i < 40 && PENABLE; i++) begin
      acc++;
      tick();
    end
    check("t4_access_cycles", acc, 16);
    check("t4_rsp_valid", RSP_VALID, 2'b01);
    check("t4_rsp_err", RSP_ERR, 1'b1);
    check("t4_rsp_rdata", RSP_RDATA, 32'h0);
    check("t4_bus_idle", {PSEL1, PSEL2, PENABLE}, 3'b000);
    REQ_ADDR[2*AW-1:AW] = 32'h100; REQ_WRITE[1] = 1'b1; REQ_WDATA[2*DW-1:DW] = 32'h77;
    REQ_STRB[2*SW-1:SW] = 4'h3; REQ_VALID = 2'b10; PREADY = 1'b1;
    #1;
    check("t4_next_ready", REQ_READY, 2'b10);
    tick(); REQ_VALID = 2'b00;
    check("t4_next_pstrb", PSTRB, 4'h3);
    check("t4_next_sel", {PSEL1, PSEL2}, 2'b01);
    tick(); tick();
    check("t4_next_rsp", RSP_VALID, 2'b10);
    check("t4_next_err", RSP_ERR, 1'b0);
    PREADY = 1'b0;

    // Slave error on a read: error flagged, raw read data passed through
    REQ_ADDR[AW-1:0] = 32'h20; REQ_WRITE[0] = 1'b0; REQ_VALID = 2'b01;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_F00D;
    #1;
    check("t5_ready", REQ_READY, 2'b01);
    tick(); REQ_VALID = 2'b00;
    tick(); tick();
    check("t5_rsp_valid", RSP_VALID, 2'b01);
    check("t5_rsp_err", RSP_ERR, 1'b1);
    check("t5_rsp_rdata", RSP_RDATA, 32'hCAFE_F00D);
    tick();
    check("t5_rsp_pulse", RSP_VALID, 2'b00);
    check("t5_err_hold", RSP_ERR, 1'b1);
    PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset during ACCESS; afterwards requester 0 wins first even though it was last granted
    REQ_ADDR[AW-1:0] = 32'h30; REQ_VALID = 2'b01;
    #1;
    check("t6_ready", REQ_READY, 2'b01);
    tick(); REQ_VALID = 2'b00;
    tick();
    check("t6_in_access", PENABLE, 1'b1);
    #2 PRESETn = 1'b0; PREADY = 1'b1;
    #1;
    check("t6_rst_ctrl", {PSEL1, PSEL2, PENABLE, PWRITE, RSP_ERR, RSP_VALID}, 7'b0);
    check("t6_rst_data", {PADDR, RSP_RDATA}, 64'h0);
    check("t6_rst_state", state_dbg, 2'd0);
    tick(); tick();
    check("t6_no_rsp", RSP_VALID, 2'b00);
    PRESETn = 1'b1; PREADY = 1'b0;
    REQ_VALID = 2'b11;
    #1;
    check("t6_first_grant", REQ_READY, 2'b01);
    tick();
    check("t6_paddr", PADDR, 32'h30);
    REQ_VALID = 2'b00;
    tick(); PREADY = 1'b1;
    tick();
    check("t6_rsp_valid", RSP_VALID, 2'b01);
    PREADY = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
